// File: rtl/control_unit.sv
// Multicycle control FSM for the memory-to-memory CPU datapath.
// Ports: CLK, reset (async active-low), OPOut, ioValid; datapath selects, write enables, ioStrobe, halted, illegal.
module control_unit #(
  parameter bit RESET_HALTED = 1'b0
) (
  input  logic       CLK,
  input  logic       reset,
  input  logic [7:0] OPOut,
  input  logic       ioValid,
  output logic       inputPC,
  output logic       regOrPC,
  output logic       valA,
  output logic       branch,
  output logic [1:0] memAddr,
  output logic [1:0] memWriteData,
  output logic [1:0] ALUsrca,
  output logic [1:0] ALUsrcb,
  output logic [3:0] ALUOp,
  output logic       writeOp,
  output logic       writeA,
  output logic       writeB,
  output logic       writeDest,
  output logic       writePC,
  output logic       writeSP,
  output logic       writeMem,
  output logic       ioStrobe,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [4:0] {
    S_FETCH, S_DECODE,
    S_FA1, S_FA2, S_FB1, S_FB2, S_FD,
    S_EX, S_BR, S_SPD, S_PW,
    S_PR, S_PDW, S_SPI,
    S_IW, S_OS, S_HALT
  } state_t;

  localparam state_t RST_ST =
    RESET_HALTED ? S_HALT : S_FETCH;

  state_t     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [3:0] cls;
  logic [3:0] fn;
  logic       bad;

  assign cls = OPOut[7:4];
  assign fn  = OPOut[3:0];

  // Undefined class, or ALU class with a function code past PASSB.
  assign bad = (cls >= 4'h7 && cls <= 4'hE)
            || (cls == 4'h1 && fn > 4'h8);

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= RST_ST;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          bad: begin
            state_d   = S_HALT;
            illegal_d = 1'b1;
          end
          (cls == 4'h0): state_d = S_FETCH;
          (cls == 4'h4),
          (cls == 4'h5): state_d = S_FD;
          (cls == 4'hF): state_d = S_HALT;
          default:       state_d = S_FA1;
        endcase
      end
      S_FA1: state_d = S_FA2;
      S_FA2: begin
        unique case (1'b1)
          (cls == 4'h3): state_d = S_SPD;
          (cls == 4'h6): state_d = S_OS;
          default:       state_d = S_FB1;
        endcase
      end
      S_FB1: state_d = S_FB2;
      S_FB2: begin
        state_d = (cls == 4'h2) ? S_BR : S_FD;
      end
      S_FD: begin
        unique case (1'b1)
          (cls == 4'h4): state_d = S_PR;
          (cls == 4'h5): state_d = S_IW;
          default:       state_d = S_EX;
        endcase
      end
      S_EX:  state_d = S_FETCH;
      S_BR:  state_d = S_FETCH;
      S_SPD: state_d = S_PW;
      S_PW:  state_d = S_FETCH;
      S_PR:  state_d = S_PDW;
      S_PDW: state_d = S_SPI;
      S_SPI: state_d = S_FETCH;
      S_IW: begin
        if (ioValid) state_d = S_FETCH;
      end
      S_OS:   state_d = S_FETCH;
      S_HALT: state_d = S_HALT;
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    inputPC      = 1'b0;
    regOrPC      = 1'b0;
    valA         = 1'b0;
    branch       = 1'b0;
    memAddr      = 2'd0;
    memWriteData = 2'd0;
    ALUsrca      = 2'd0;
    ALUsrcb      = 2'd0;
    ALUOp        = 4'd0;
    writeOp      = 1'b0;
    writeA       = 1'b0;
    writeB       = 1'b0;
    writeDest    = 1'b0;
    writePC      = 1'b0;
    writeSP      = 1'b0;
    writeMem     = 1'b0;
    ioStrobe     = 1'b0;
    halted       = (state_q == S_HALT);
    illegal      = illegal_q;
    // Held in reset, nothing may reach the datapath.
    if (reset) begin
      unique case (state_q)
        S_FETCH: begin
          writeOp = 1'b1;
          writePC = 1'b1;
        end
        S_FA1: begin
          writeA  = 1'b1;
          writePC = 1'b1;
        end
        S_FB1: begin
          writeB  = 1'b1;
          writePC = 1'b1;
        end
        S_FD: begin
          writeDest = 1'b1;
          writePC   = 1'b1;
        end
        S_FA2: begin
          memAddr = 2'd1;
          valA    = 1'b1;
          writeA  = 1'b1;
        end
        S_FB2: begin
          memAddr = 2'd1;
          valA    = 1'b1;
          writeB  = 1'b1;
        end
        S_EX: begin
          ALUsrca  = 2'd1;
          ALUsrcb  = 2'd1;
          ALUOp    = fn;
          memAddr  = 2'd3;
          writeMem = 1'b1;
        end
        S_BR: begin
          ALUsrca = 2'd1;
          ALUsrcb = 2'd1;
          ALUOp   = 4'd1;
          branch  = 1'b1;
          regOrPC = 1'b1;
          inputPC = 1'b1;
          writePC = 1'b1;
        end
        S_SPD: begin
          ALUsrca = 2'd2;
          ALUOp   = 4'd1;
          writeSP = 1'b1;
        end
        S_PW: begin
          memAddr      = 2'd2;
          memWriteData = 2'd1;
          writeMem     = 1'b1;
        end
        S_PR: begin
          memAddr = 2'd2;
          writeB  = 1'b1;
        end
        S_PDW: begin
          ALUsrcb  = 2'd1;
          ALUOp    = 4'd8;
          memAddr  = 2'd3;
          writeMem = 1'b1;
        end
        S_SPI: begin
          ALUsrca = 2'd2;
          writeSP = 1'b1;
        end
        S_IW: begin
          if (ioValid) begin
            memAddr      = 2'd3;
            memWriteData = 2'd3;
            writeMem     = 1'b1;
          end
        end
        S_OS: ioStrobe = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: random opcode stream vs. a microstep model.
// Stimulus pushes per-cycle expectations; a negedge monitor pops and compares.
module tb_control_unit;

  logic       CLK = 1'b0;
  logic       reset;
  logic [7:0] OPOut;
  logic       ioValid;
  logic       inputPC, regOrPC, valA, branch;
  logic [1:0] memAddr, memWriteData, ALUsrca, ALUsrcb;
  logic [3:0] ALUOp;
  logic       writeOp, writeA, writeB, writeDest;
  logic       writePC, writeSP, writeMem;
  logic       ioStrobe, halted, illegal;

  control_unit #(.RESET_HALTED(1'b0)) dut (
    .CLK(CLK), .reset(reset), .OPOut(OPOut),
    .ioValid(ioValid),
    .inputPC(inputPC), .regOrPC(regOrPC),
    .valA(valA), .branch(branch),
    .memAddr(memAddr), .memWriteData(memWriteData),
    .ALUsrca(ALUsrca), .ALUsrcb(ALUsrcb),
    .ALUOp(ALUOp), .writeOp(writeOp),
    .writeA(writeA), .writeB(writeB),
    .writeDest(writeDest), .writePC(writePC),
    .writeSP(writeSP), .writeMem(writeMem),
    .ioStrobe(ioStrobe), .halted(halted),
    .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       inputPC, regOrPC, valA, branch;
    logic [1:0] memAddr, memWriteData;
    logic [1:0] ALUsrca, ALUsrcb;
    logic [3:0] ALUOp;
    logic       writeOp, writeA, writeB, writeDest;
    logic       writePC, writeSP, writeMem;
    logic       ioStrobe, halted, illegal;
  } vec_t;

  typedef enum {
    T_FETCH, T_DECODE, T_FA1, T_FA2, T_FB1,
    T_FB2, T_FD, T_EX, T_BR, T_SPD, T_PW,
    T_PR, T_PDW, T_SPI, T_IW0, T_IW1,
    T_OS, T_HALT
  } step_t;

  vec_t act;
  assign act = {inputPC, regOrPC, valA, branch,
                memAddr, memWriteData, ALUsrca,
                ALUsrcb, ALUOp, writeOp, writeA,
                writeB, writeDest, writePC, writeSP,
                writeMem, ioStrobe, halted, illegal};

  int    checks = 0;
  int    failures = 0;
  vec_t  exp_q[$];
  string name_q[$];
  step_t plan[$];
  bit    ill_m = 1'b0;

  // Expected control word for one microstep, straight from the step table.
  function automatic vec_t mk(step_t s, logic [3:0] f, bit ill);
    vec_t v = '0;
    v.illegal = ill;
    case (s)
      T_FETCH: begin v.writeOp = 1; v.writePC = 1; end
      T_FA1:   begin v.writeA = 1; v.writePC = 1; end
      T_FB1:   begin v.writeB = 1; v.writePC = 1; end
      T_FD:    begin v.writeDest = 1; v.writePC = 1; end
      T_FA2:   begin v.memAddr = 1; v.valA = 1; v.writeA = 1; end
      T_FB2:   begin v.memAddr = 1; v.valA = 1; v.writeB = 1; end
      T_EX: begin
        v.ALUsrca = 1; v.ALUsrcb = 1; v.ALUOp = f;
        v.memAddr = 3; v.writeMem = 1;
      end
      T_BR: begin
        v.ALUsrca = 1; v.ALUsrcb = 1; v.ALUOp = 1;
        v.branch = 1; v.regOrPC = 1; v.inputPC = 1;
        v.writePC = 1;
      end
      T_SPD: begin v.ALUsrca = 2; v.ALUOp = 1; v.writeSP = 1; end
      T_PW: begin
        v.memAddr = 2; v.memWriteData = 1; v.writeMem = 1;
      end
      T_PR:  begin v.memAddr = 2; v.writeB = 1; end
      T_PDW: begin
        v.ALUsrcb = 1; v.ALUOp = 8; v.memAddr = 3; v.writeMem = 1;
      end
      T_SPI: begin v.ALUsrca = 2; v.writeSP = 1; end
      T_IW1: begin
        v.memAddr = 3; v.memWriteData = 3; v.writeMem = 1;
      end
      T_OS:   v.ioStrobe = 1;
      T_HALT: v.halted = 1;
      default: ;
    endcase
    return v;
  endfunction

  function automatic bit is_bad(logic [7:0] op);
    return (op[7:4] >= 4'h7 && op[7:4] <= 4'hE)
        || (op[7:4] == 4'h1 && op[3:0] > 4'h8);
  endfunction

  task automatic plan_instr(input logic [7:0] op, input int n);
    plan.delete();
    plan.push_back(T_FETCH);
    plan.push_back(T_DECODE);
    if (is_bad(op) || op[7:4] == 4'hF) begin
      for (int i = 0; i < n; i++) plan.push_back(T_HALT);
    end else begin
      case (op[7:4])
        4'h1: plan = {plan, T_FA1, T_FA2, T_FB1, T_FB2, T_FD, T_EX};
        4'h2: plan = {plan, T_FA1, T_FA2, T_FB1, T_FB2, T_BR};
        4'h3: plan = {plan, T_FA1, T_FA2, T_SPD, T_PW};
        4'h4: plan = {plan, T_FD, T_PR, T_PDW, T_SPI};
        4'h5: begin
          plan.push_back(T_FD);
          for (int i = 0; i < n; i++) plan.push_back(T_IW0);
          plan.push_back(T_IW1);
        end
        4'h6: plan = {plan, T_FA1, T_FA2, T_OS};
        default: ;
      endcase
    end
  endtask

  task automatic chk_idle(input string nm, input bit h, input bit il);
    vec_t e = '0;
    e.halted = h;
    e.illegal = il;
    checks++;
    if (act !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, e);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    ill_m = 1'b0;
    #1;
    chk_idle("reset_idle", 1'b0, 1'b0);
    @(posedge CLK); #1;
    reset = 1'b1;
  endtask

  // Runs one instruction; abort_at >= 0 asserts reset inside that step.
  task automatic run_instr(input logic [7:0] op, input int n,
                           input int abort_at);
    plan_instr(op, n);
    OPOut = op;
    for (int i = 0; i < plan.size(); i++) begin
      step_t s = plan[i];
      if (s == T_IW0) ioValid = 1'b0;
      else if (s == T_IW1) ioValid = 1'b1;
      else ioValid = 1'($urandom_range(0, 1));
      exp_q.push_back(mk(s, op[3:0], ill_m));
      name_q.push_back($sformatf("%s op=%h", s.name(), op));
      if (s == T_DECODE && is_bad(op)) ill_m = 1'b1;
      if (i == abort_at) begin
        @(negedge CLK); #1;
        reset = 1'b0;
        ill_m = 1'b0;
        #1;
        checks++;
        if (writeMem !== 1'b0) begin
          failures++;
          $display("FAIL abort_writeMem got=%b exp=0", writeMem);
        end
        chk_idle("abort_idle", 1'b0, 1'b0);
        @(posedge CLK); #1;
        reset = 1'b1;
        return;
      end
      @(posedge CLK); #1;
    end
    if (is_bad(op) || op[7:4] == 4'hF) do_reset();
  endtask

  initial begin : monitor
    vec_t  e;
    string nm;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        nm = name_q.pop_front();
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL %s got=%h exp=%h", nm, act, e);
        end
      end
    end
  end

  initial begin : stim
    logic [7:0] op;
    reset = 1'b0;
    OPOut = 8'h00;
    ioValid = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk_idle("reset_hold", 1'b0, 1'b0);
    reset = 1'b1;
    run_instr(8'h10, 0, -1);
    run_instr(8'h10, 0, 7);
    run_instr(8'h30, 0, -1);
    run_instr(8'h40, 0, -1);
    run_instr(8'h50, 5, -1);
    run_instr(8'h60, 0, -1);
    run_instr(8'h20, 0, -1);
    run_instr(8'h00, 0, -1);
    run_instr(8'hF0, 10, -1);
    run_instr(8'h90, 20, -1);
    run_instr(8'h1C, 5, -1);
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 7) == 0)
        op = 8'($urandom_range(0, 255));
      else
        op = {4'($urandom_range(0, 6)), 4'($urandom_range(0, 8))};
      run_instr(op, int'($urandom_range(0, 6)),
                ($urandom_range(0, 19) == 0) ? 2 : -1);
    end
    @(negedge CLK); #1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
